// File: rtl/mips_memory_stage.sv
// mips_memory_stage
//   MEM pipeline stage sitting between execute and writeback. Latches the
//   instruction handed over by EXE, issues loads/stores on the data-memory
//   request/response bus, aligns and extends load data, and offers the result
//   to WB through the valid / ready_go / allowin handshake.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   exe_valid_ready_go            EXE holds a finished instruction
//   mem_allowin                   this stage can take a new instruction
//   exe_out_op .. exe_lo_value    instruction fields from EXE
//   mem_valid                     this stage holds an instruction
//   mem_valid_ready_go            result is ready for WB
//   wb_allowin                    WB can take the result
//   mem_out_op .. mem_lo_value    registered instruction fields / result to WB
//   data_req .. data_wdata        request half of the data-memory bus
//   data_addr_ok, data_data_ok,
//   data_rdata                    response half of the data-memory bus
//
// Op bundle bits used here: 16 MemRead, 17 MemWrite, 19:18 access size
// (00 byte, 01 half, 10 word), 20 unsigned load.

module mips_memory_stage #(
  parameter int OP_W   = 32,
  parameter int RW_BIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid_ready_go,
  output logic            mem_allowin,
  input  logic [OP_W-1:0] exe_out_op,
  input  logic [4:0]      exe_rf_waddr,
  input  logic [31:0]     exe_value,
  input  logic [31:0]     exe_store_data,
  input  logic [31:0]     exe_pc,
  input  logic [31:0]     exe_instruction,
  input  logic [31:0]     exe_hi_value,
  input  logic [31:0]     exe_lo_value,
  output logic            mem_valid,
  output logic            mem_valid_ready_go,
  input  logic            wb_allowin,
  output logic [OP_W-1:0] mem_out_op,
  output logic [4:0]      mem_rf_waddr,
  output logic [31:0]     mem_value,
  output logic [31:0]     mem_pc,
  output logic [31:0]     mem_instruction,
  output logic [31:0]     mem_hi_value,
  output logic [31:0]     mem_lo_value,
  output logic            data_req,
  output logic            data_wr,
  output logic [1:0]      data_size,
  output logic [31:0]     data_addr,
  output logic [31:0]     data_wdata,
  input  logic            data_addr_ok,
  input  logic            data_data_ok,
  input  logic [31:0]     data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        mem_ready_go;
  logic        mem_is_mem;
  logic        exe_is_mem;
  logic        latch_exe;
  logic [31:0] mem_store_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // A memory op holds the stage until its bus response has come back; all
  // other ops are ready as soon as they are latched.
  assign mem_is_mem         = mem_out_op[16] | mem_out_op[17];
  assign exe_is_mem         = exe_out_op[16] | exe_out_op[17];
  assign mem_ready_go       = !mem_is_mem || (state == S_DONE);
  assign mem_allowin        = !mem_valid || (mem_ready_go && wb_allowin);
  assign mem_valid_ready_go = mem_valid && mem_ready_go;
  assign latch_exe          = exe_valid_ready_go && mem_allowin;

  // Bus transaction state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Whenever the stage accepts (an instruction or a bubble) the FSM restarts
  // from what was just accepted. Otherwise it only advances on bus responses;
  // DONE simply holds while WB is stalled. A stray data_data_ok in IDLE, such
  // as one left over from a transaction abandoned by reset, is ignored here.
  always_comb begin
    state_next = state;
    if (mem_allowin) begin
      state_next = (exe_valid_ready_go && exe_is_mem) ? S_REQ : S_IDLE;
    end else begin
      case (state)
        S_REQ:   if (data_addr_ok) state_next = S_WAIT;
        S_WAIT:  if (data_data_ok) state_next = S_DONE;
        default: state_next = state;
      endcase
    end
  end

  // Bus request outputs. The address is the latched effective address and
  // store data is replicated across every lane so the slave can pick the
  // byte/half it needs using the low address bits.
  always_comb begin
    data_req   = (state == S_REQ);
    data_wr    = mem_out_op[17];
    data_size  = mem_out_op[19:18];
    data_addr  = mem_value;
    data_wdata = mem_store_data;
    case (mem_out_op[19:18])
      2'b00:   data_wdata = {4{mem_store_data[7:0]}};
      2'b01:   data_wdata = {2{mem_store_data[15:0]}};
      default: data_wdata = mem_store_data;
    endcase
  end

  // Load alignment and extension. Halfword loads select on address bit 1
  // only; a misaligned halfword is not trapped, bit 0 is just dropped.
  always_comb begin
    load_byte = data_rdata[7:0];
    case (mem_value[1:0])
      2'd0:    load_byte = data_rdata[7:0];
      2'd1:    load_byte = data_rdata[15:8];
      2'd2:    load_byte = data_rdata[23:16];
      default: load_byte = data_rdata[31:24];
    endcase
    load_half = mem_value[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_data = data_rdata;
    case (mem_out_op[19:18])
      2'b00:   load_data = mem_out_op[20] ? {24'h0, load_byte}
                                          : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_data = mem_out_op[20] ? {16'h0, load_half}
                                          : {{16{load_half[15]}}, load_half};
      default: load_data = data_rdata;
    endcase
  end

  // Pipeline registers. Everything is captured on an accepting edge and
  // frozen otherwise, except that a returning load overwrites the address in
  // mem_value with the extended data. RegWrite is spliced in on its own so
  // its position in the bundle is explicit; it is copied, never modified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid       <= 1'b0;
      mem_out_op      <= '0;
      mem_rf_waddr    <= '0;
      mem_value       <= '0;
      mem_store_data  <= '0;
      mem_pc          <= '0;
      mem_instruction <= '0;
      mem_hi_value    <= '0;
      mem_lo_value    <= '0;
    end else begin
      if (mem_allowin) begin
        mem_valid <= exe_valid_ready_go;
      end
      if (latch_exe) begin
        mem_out_op      <= {exe_out_op[OP_W-1:RW_BIT+1], exe_out_op[RW_BIT],
                            exe_out_op[RW_BIT-1:0]};
        mem_rf_waddr    <= exe_rf_waddr;
        mem_value       <= exe_value;
        mem_store_data  <= exe_store_data;
        mem_pc          <= exe_pc;
        mem_instruction <= exe_instruction;
        mem_hi_value    <= exe_hi_value;
        mem_lo_value    <= exe_lo_value;
      end else if (state == S_WAIT && data_data_ok && mem_out_op[16]) begin
        mem_value <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_memory_stage.sv
// tb_mips_memory_stage
//   Directed bench for mips_memory_stage. A table of single-instruction
//   vectors (op, address, store data, read data, bus delays and hand-computed
//   results) is played through the stage with the bench acting as the bus
//   slave, followed by hand-written sequences for a WB stall and for a reset
//   that lands in the middle of a transaction.

module tb_mips_memory_stage;

  logic        clk;
  logic        rst;
  logic        exe_valid_ready_go;
  logic        mem_allowin;
  logic [31:0] exe_out_op;
  logic [4:0]  exe_rf_waddr;
  logic [31:0] exe_value;
  logic [31:0] exe_store_data;
  logic [31:0] exe_pc;
  logic [31:0] exe_instruction;
  logic [31:0] exe_hi_value;
  logic [31:0] exe_lo_value;
  logic        mem_valid;
  logic        mem_valid_ready_go;
  logic        wb_allowin;
  logic [31:0] mem_out_op;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_value;
  logic [31:0] mem_pc;
  logic [31:0] mem_instruction;
  logic [31:0] mem_hi_value;
  logic [31:0] mem_lo_value;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  // Op bundles: bit15 RegWrite, 16 MemRead, 17 MemWrite, 19:18 size, 20 unsigned.
  localparam logic [31:0] OP_ALU = 32'h0000_8008;
  localparam logic [31:0] OP_LB  = 32'h0001_8000;
  localparam logic [31:0] OP_LBU = 32'h0011_8000;
  localparam logic [31:0] OP_LH  = 32'h0005_8000;
  localparam logic [31:0] OP_LHU = 32'h0015_8000;
  localparam logic [31:0] OP_LW  = 32'h0009_8000;
  localparam logic [31:0] OP_SB  = 32'h0002_0000;
  localparam logic [31:0] OP_SH  = 32'h0006_0000;
  localparam logic [31:0] OP_SW  = 32'h000A_0000;

  typedef struct {
    logic [31:0] op;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] rdata;
    int          addr_dly;
    int          data_dly;
    logic [31:0] exp_value;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NUM_VECS = 11;
  vec_t vecs[NUM_VECS];

  mips_memory_stage #(.OP_W(32), .RW_BIT(15)) dut (
    .clk                (clk),
    .rst                (rst),
    .exe_valid_ready_go (exe_valid_ready_go),
    .mem_allowin        (mem_allowin),
    .exe_out_op         (exe_out_op),
    .exe_rf_waddr       (exe_rf_waddr),
    .exe_value          (exe_value),
    .exe_store_data     (exe_store_data),
    .exe_pc             (exe_pc),
    .exe_instruction    (exe_instruction),
    .exe_hi_value       (exe_hi_value),
    .exe_lo_value       (exe_lo_value),
    .mem_valid          (mem_valid),
    .mem_valid_ready_go (mem_valid_ready_go),
    .wb_allowin         (wb_allowin),
    .mem_out_op         (mem_out_op),
    .mem_rf_waddr       (mem_rf_waddr),
    .mem_value          (mem_value),
    .mem_pc             (mem_pc),
    .mem_instruction    (mem_instruction),
    .mem_hi_value       (mem_hi_value),
    .mem_lo_value       (mem_lo_value),
    .data_req           (data_req),
    .data_wr            (data_wr),
    .data_size          (data_size),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_addr_ok       (data_addr_ok),
    .data_data_ok       (data_data_ok),
    .data_rdata         (data_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] op, input logic [31:0] addr,
                                 input logic [31:0] st_data, input logic [31:0] rdata,
                                 input int addr_dly, input int data_dly,
                                 input logic [31:0] exp_value,
                                 input logic [31:0] exp_wdata);
    vec_t v;
    v.op = op;           v.addr = addr;
    v.st_data = st_data; v.rdata = rdata;
    v.addr_dly = addr_dly; v.data_dly = data_dly;
    v.exp_value = exp_value; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Plays one instruction through the stage with WB always ready. Entered
  // and left just after a falling edge with the stage empty. The bench acts
  // as the bus slave, raising addr_ok after addr_dly request cycles and
  // data_ok data_dly cycles after the cycle following addr_ok.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic        is_mem;
    logic        blocked_bad;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] got_addr;
    logic [31:0] got_wdata;
    logic [31:0] got_wr;
    logic [31:0] got_size;
    int          c;
    int          req_cycles;
    int          exp_lat;
    string       tag;

    is_mem  = v.op[16] | v.op[17];
    exp_lat = is_mem ? v.addr_dly + v.data_dly + 2 : 0;
    pc      = 32'h0040_0000 + 32'(idx) * 4;
    waddr   = 5'(idx + 1);
    tag     = $sformatf("v%0d", idx);

    exe_valid_ready_go = 1'b1;
    exe_out_op         = v.op;
    exe_rf_waddr       = waddr;
    exe_value          = v.addr;
    exe_store_data     = v.st_data;
    exe_pc             = pc;
    exe_instruction    = ~pc;
    exe_hi_value       = pc ^ 32'hA5A5_0000;
    exe_lo_value       = {pc[15:0], pc[31:16]};
    wb_allowin         = 1'b1;
    data_rdata         = v.rdata;
    #1;
    checkOutput({tag, ".allowinEmpty"}, 32'(mem_allowin), 32'd1);

    @(negedge clk);
    exe_valid_ready_go = 1'b0;
    exe_out_op         = 32'hFFFF_FFFF;
    exe_value          = 32'hDEAD_0000;
    exe_store_data     = 32'h5555_5555;
    exe_pc             = 32'h0;

    req_cycles  = 0;
    blocked_bad = 1'b0;
    got_addr    = 32'h0;
    got_wdata   = 32'h0;
    got_wr      = 32'h0;
    got_size    = 32'h0;
    for (c = 0; c < 40; c++) begin
      if (mem_valid_ready_go) break;
      if (mem_allowin) blocked_bad = 1'b1;
      if (data_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          got_addr  = data_addr;
          got_wdata = data_wdata;
          got_wr    = 32'(data_wr);
          got_size  = 32'(data_size);
        end
      end
      data_addr_ok = is_mem && (c == v.addr_dly);
      data_data_ok = is_mem && (c == v.addr_dly + 1 + v.data_dly);
      @(negedge clk);
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;

    checkOutput({tag, ".latency"},     32'(c), 32'(exp_lat));
    checkOutput({tag, ".value"},       mem_value, v.exp_value);
    checkOutput({tag, ".reqCycles"},   32'(req_cycles), is_mem ? 32'(v.addr_dly + 1) : 32'd0);
    checkOutput({tag, ".allowinHeld"}, 32'(blocked_bad), 32'd0);
    checkOutput({tag, ".reqIdle"},     32'(data_req), 32'd0);
    checkOutput({tag, ".op"},          mem_out_op, v.op);
    checkOutput({tag, ".waddr"},       32'(mem_rf_waddr), 32'(waddr));
    checkOutput({tag, ".pc"},          mem_pc, pc);
    checkOutput({tag, ".instr"},       mem_instruction, ~pc);
    checkOutput({tag, ".hi"},          mem_hi_value, pc ^ 32'hA5A5_0000);
    checkOutput({tag, ".lo"},          mem_lo_value, {pc[15:0], pc[31:16]});
    if (is_mem) begin
      checkOutput({tag, ".addr"},  got_addr, v.addr);
      checkOutput({tag, ".wr"},    got_wr, 32'(v.op[17]));
      checkOutput({tag, ".size"},  got_size, 32'(v.op[19:18]));
      checkOutput({tag, ".wdata"}, got_wdata, v.exp_wdata);
    end

    @(negedge clk);
    checkOutput({tag, ".drained"}, 32'(mem_valid), 32'd0);
  endtask

  initial begin
    // Vector table: op, addr, store data, read data, addr delay, data delay,
    // expected mem_value, expected data_wdata.
    vecs[0]  = mkVec(OP_ALU, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 32'h1234_5678, 32'h0);
    vecs[1]  = mkVec(OP_LB,  32'h0000_0103, 32'h0,         32'h80FF_00AA, 0, 0, 32'hFFFF_FF80, 32'h0);
    vecs[2]  = mkVec(OP_LHU, 32'h0000_0102, 32'h0,         32'h9ABC_1234, 1, 0, 32'h0000_9ABC, 32'h0);
    vecs[3]  = mkVec(OP_LH,  32'h0000_0100, 32'h0,         32'h9ABC_1234, 0, 1, 32'h0000_1234, 32'h0);
    vecs[4]  = mkVec(OP_LBU, 32'h0000_0102, 32'h0,         32'h80FF_00AA, 0, 0, 32'h0000_00FF, 32'h0);
    vecs[5]  = mkVec(OP_LW,  32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 32'h0);
    vecs[6]  = mkVec(OP_SB,  32'h0000_0300, 32'h0000_00A5, 32'h0,         3, 0, 32'h0000_0300, 32'hA5A5_A5A5);
    vecs[7]  = mkVec(OP_SH,  32'h0000_0302, 32'h1234_BEEF, 32'h0,         0, 0, 32'h0000_0302, 32'hBEEF_BEEF);
    vecs[8]  = mkVec(OP_SW,  32'h0000_0304, 32'hCAFE_F00D, 32'h0,         1, 1, 32'h0000_0304, 32'hCAFE_F00D);
    vecs[9]  = mkVec(OP_LH,  32'h0000_0106, 32'h0,         32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 32'h0);
    vecs[10] = mkVec(OP_LH,  32'h0000_0101, 32'h0,         32'h8001_7FFF, 0, 0, 32'h0000_7FFF, 32'h0);

    rst = 1'b1;
    exe_valid_ready_go = 1'b0;
    exe_out_op = 32'h0; exe_rf_waddr = 5'h0; exe_value = 32'h0;
    exe_store_data = 32'h0; exe_pc = 32'h0; exe_instruction = 32'h0;
    exe_hi_value = 32'h0; exe_lo_value = 32'h0;
    wb_allowin = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    #1;
    checkOutput("reset.valid",   32'(mem_valid), 32'd0);
    checkOutput("reset.vrg",     32'(mem_valid_ready_go), 32'd0);
    checkOutput("reset.req",     32'(data_req), 32'd0);
    checkOutput("reset.value",   mem_value, 32'h0);
    checkOutput("reset.addr",    data_addr, 32'h0);
    checkOutput("reset.allowin", 32'(mem_allowin), 32'd1);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i], i);
    end

    // WB stall: a load finishes while WB refuses it for two edges; the
    // waiting ALU op in EXE must not be taken until WB comes back.
    exe_valid_ready_go = 1'b1;
    exe_out_op = OP_LW; exe_value = 32'h0000_0400; exe_store_data = 32'h0;
    data_rdata = 32'h1357_9BDF;
    wb_allowin = 1'b0;
    @(negedge clk);
    exe_out_op = OP_ALU; exe_value = 32'h0000_0055;
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    checkOutput("stall.allowinWait", 32'(mem_allowin), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0;
    checkOutput("stall.vrg1",     32'(mem_valid_ready_go), 32'd1);
    checkOutput("stall.value1",   mem_value, 32'h1357_9BDF);
    checkOutput("stall.allowin1", 32'(mem_allowin), 32'd0);
    @(negedge clk);
    checkOutput("stall.vrg2",   32'(mem_valid_ready_go), 32'd1);
    checkOutput("stall.value2", mem_value, 32'h1357_9BDF);
    checkOutput("stall.op2",    mem_out_op, OP_LW);
    checkOutput("stall.req2",   32'(data_req), 32'd0);
    @(negedge clk);
    checkOutput("stall.value3",   mem_value, 32'h1357_9BDF);
    checkOutput("stall.allowin3", 32'(mem_allowin), 32'd0);
    wb_allowin = 1'b1;
    #1;
    checkOutput("stall.allowinBack", 32'(mem_allowin), 32'd1);
    @(negedge clk);
    exe_valid_ready_go = 1'b0;
    checkOutput("stall.nextValue", mem_value, 32'h0000_0055);
    checkOutput("stall.nextOp",    mem_out_op, OP_ALU);
    checkOutput("stall.nextVrg",   32'(mem_valid_ready_go), 32'd1);
    @(negedge clk);
    checkOutput("stall.drained", 32'(mem_valid), 32'd0);

    // Reset lands between clock edges while a load is in WAIT; the late
    // data_ok that follows must be ignored.
    exe_valid_ready_go = 1'b1;
    exe_out_op = OP_LW; exe_value = 32'h0000_0500;
    @(negedge clk);
    exe_valid_ready_go = 1'b0;
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    checkOutput("rstMid.waitReq",   32'(data_req), 32'd0);
    checkOutput("rstMid.waitValid", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstMid.valid",   32'(mem_valid), 32'd0);
    checkOutput("rstMid.req",     32'(data_req), 32'd0);
    checkOutput("rstMid.value",   mem_value, 32'h0);
    checkOutput("rstMid.allowin", 32'(mem_allowin), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    data_rdata = 32'hFFFF_FFFF;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    checkOutput("rstMid.lateValid", 32'(mem_valid), 32'd0);
    checkOutput("rstMid.lateVrg",   32'(mem_valid_ready_go), 32'd0);
    checkOutput("rstMid.lateValue", mem_value, 32'h0);
    applyStimulus(mkVec(OP_LW, 32'h0000_0504, 32'h0, 32'h2468_ACE0, 0, 0,
                        32'h2468_ACE0, 32'h0), 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_memory_stage.md
Name: mips_memory_stage

Overview:
- MEM pipeline stage between execute and writeback.
- Issues load/store requests on the data-memory request/response bus and aligns and extends load data.
- Presents results to writeback through the valid / ready_go / allowin handshake; it is the upstream sender for the writeback stage's mem_* inputs.
- Non-memory instructions pass through in one cycle. Memory instructions stall the stage until the bus response arrives.

Parameters:
- OP_W, 32, width of the op control bundle.
- RW_BIT, 15, op bit index of RegWrite; passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exe_valid_ready_go  in  1  EXE holds a valid, finished instruction
- mem_allowin  out  1  MEM can accept this cycle
- exe_out_op  in  OP_W  control bundle; bit16 MemRead, bit17 MemWrite, bits19:18 size (00 byte, 01 half, 10 word), bit20 unsigned load
- exe_rf_waddr  in  5  destination register
- exe_value  in  32  ALU result / effective address
- exe_store_data  in  32  rt value for stores
- exe_pc, exe_instruction, exe_hi_value, exe_lo_value  in  32 each  sideband
- mem_valid  out  1  stage holds an instruction
- mem_valid_ready_go  out  1  to WB
- wb_allowin  in  1  from WB
- mem_out_op  out  OP_W  registered op
- mem_rf_waddr  out  5  registered destination register
- mem_value  out  32  final result
- mem_pc, mem_instruction, mem_hi_value, mem_lo_value  out  32 each  registered sideband
- data_req  out  1  request valid
- data_wr  out  1  1 = store
- data_size  out  2  op[19:18]
- data_addr  out  32  request address
- data_wdata  out  32  store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data / write ack
- data_rdata  in  32  read data

Behaviour:
- Reset: asynchronous, active-high. All registers clear immediately: mem_valid=0, FSM=IDLE, all data outputs 0, data_req=0.
- Reset mid-transaction abandons it. The bus slave is reset with the same rst, and any late data_data_ok is ignored in IDLE.
- Handshake:
  - mem_allowin = !mem_valid | (mem_ready_go & wb_allowin).
  - mem_valid_ready_go = mem_valid & mem_ready_go.
  - On a clock edge with mem_allowin=1: mem_valid <= exe_valid_ready_go.
  - On a clock edge with exe_valid_ready_go & mem_allowin: latch every exe_* field.
  - Registers hold while mem_allowin=0.
- mem_ready_go = 1 if the op is neither MemRead nor MemWrite; otherwise mem_ready_go = (state==DONE).
- FSM states and transitions:
  - IDLE: enter on reset, or on a latch edge of a non-memory op or a bubble.
  - REQ: entered on the latch edge of a memory op. data_req=1. data_addr = mem_value (the latched exe_value). data_wr = MemWrite. On data_addr_ok, go to WAIT.
  - WAIT: data_req=0. On data_data_ok, go to DONE. For a load, mem_value <= aligned and extended data_rdata on that edge. For a store, mem_value is unchanged.
  - DONE: mem_ready_go=1. On handoff (wb_allowin=1) the next state follows the newly latched instruction (REQ, IDLE), or IDLE if nothing arrives.
- The slave never asserts data_data_ok in the same cycle as data_addr_ok for the same request.
- Minimum memory latency: latch edge E; addr_ok in cycle E+0; data_ok in cycle E+1; valid_ready_go in cycle E+2.
- Store data:
  - byte: data_wdata = {4{st[7:0]}}
  - half: data_wdata = {2{st[15:0]}}
  - word: data_wdata = st
- Load extraction, with a = address[1:0]:
  - byte: byte a of data_rdata.
  - half: halfword address[1]; address[0] is ignored, no alignment exception.
  - word: whole word.
  - Sign-extend unless op[20]=1, then zero-extend.
- op, waddr, pc, instruction, hi and lo pass through unmodified. RegWrite (op[RW_BIT]) is never altered.
- wb_allowin=0 while in DONE: hold DONE and all outputs; issue no new request.

Test Plan:
- Non-memory op, exe_value=0x12345678, wb_allowin=1 -> mem_valid_ready_go=1 the cycle after latch; mem_value=0x12345678; data_req stays 0.
- lb, address 0x103, data_rdata=0x80FF_00AA, addr_ok immediate, data_ok one cycle later -> mem_value=0xFFFFFF80; valid_ready_go in cycle E+2.
- lhu, address 0x102, rdata=0x9ABC_1234 -> mem_value=0x00009ABC. lh, address 0x100 -> 0x00001234.
- sb, store_data=0x000000A5, addr_ok delayed 3 cycles -> data_req held for 4 cycles; data_wdata=0xA5A5A5A5; data_wr=1; data_size=00; mem_allowin=0 until DONE handoff.
- lw completes while wb_allowin=0 for 2 cycles -> stays in DONE; mem_value stable; exe_valid_ready_go not accepted; accepted the cycle wb_allowin returns to 1.
- rst pulsed mid-cycle while in WAIT -> immediate mem_valid=0, data_req=0, IDLE. A later data_data_ok is ignored; the next lw after reset completes normally.
